// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: access widths, grant codes,
// default starvation limit and the alignment rule used by the optional checker.
package mem_port_arbiter_pkg;

  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;

  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } gnt_e;

  // Reserved width, half at odd address, or word not on a 4-byte boundary.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] a);
    case (width)
      WIDTH_B: misaligned = 1'b0;
      WIDTH_H: misaligned = a[0];
      WIDTH_W: misaligned = (a != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; at_limit forces a fetch win.
module mem_arb_starve_ctr #(
  parameter int LIMIT = 4,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear dominates; increment stops at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                          cnt_d = '0;
    else if (inc_i && cnt_q != CW'(LIMIT)) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign at_limit_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one combinational-read memory port between instruction fetch and
// load/store. Data port has priority unless fetch has been starved for
// STARVE_LIMIT cycles. Responses are registered and pulse one cycle after grant.
// Optional alignment checker: define MEM_ARB_ALIGN_CHK_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_write,
  input  logic [1:0]        d_width,
  input  logic [31:0]       d_wdata,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_data,
  output logic              d_rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [1:0]        mem_width,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  gnt_e  gnt;
  logic  at_limit;
  logic  d_bad, if_bad;
  logic        if_rsp_valid_q, d_rsp_valid_q, d_rsp_err_q;
  logic [31:0] if_rsp_data_q, d_rsp_data_q;

`ifdef MEM_ARB_ALIGN_CHK_EN
  assign d_bad  = misaligned(d_width, d_addr[1:0]);
  assign if_bad = (if_addr[1:0] != 2'b00);
`else
  assign d_bad  = 1'b0;
  assign if_bad = 1'b0;
`endif

  // Per-cycle grant: data first unless fetch has hit the starvation limit.
  always_comb begin
    gnt = GNT_NONE;
    if (d_req_valid && !(if_req_valid && at_limit)) gnt = GNT_D;
    else if (if_req_valid)                          gnt = GNT_IF;
  end

  assign if_req_ready = (gnt == GNT_IF);
  assign d_req_ready  = (gnt == GNT_D);

  // Memory side mux; idle looks like a fetch read so mem_write stays low.
  always_comb begin
    mem_addr  = if_addr;
    mem_width = WIDTH_W;
    mem_write = 1'b0;
    mem_wdata = d_wdata;
    if (gnt == GNT_D) begin
      mem_addr  = d_addr;
      mem_width = d_width;
      mem_write = d_write && !d_bad;
    end
  end

  mem_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (if_req_valid && (gnt != GNT_IF)),
    .clr_i     (!if_req_valid || (gnt == GNT_IF)),
    .at_limit_o(at_limit)
  );

  // Response registers: capture read data at end of the grant cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_data_q   <= '0;
      d_rsp_err_q    <= 1'b0;
    end else begin
      if_rsp_valid_q <= (gnt == GNT_IF);
      d_rsp_valid_q  <= (gnt == GNT_D);
      d_rsp_err_q    <= (gnt == GNT_D) && d_bad;
      if (gnt == GNT_IF) if_rsp_data_q <= if_bad ? 32'h0 : mem_rdata;
      if (gnt == GNT_D)  d_rsp_data_q  <= d_bad  ? 32'h0 : mem_rdata;
    end
  end

  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rsp_data   = d_rsp_data_q;
  assign d_rsp_err    = d_rsp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte memory model on the memory side, shadow
// memory + scoreboard queues for expected responses, grant pattern capture.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_addr, if_rsp_data;
  logic        d_req_valid, d_req_ready, d_write, d_rsp_valid, d_rsp_err;
  logic [31:0] d_addr, d_wdata, d_rsp_data;
  logic [1:0]  d_width, mem_width;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_write(d_write), .d_width(d_width), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_width(mem_width),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Environment memory (what the DUT talks to) and shadow (what the bench expects).
  logic [7:0] m  [256];
  logic [7:0] sm [256];
  logic [7:0] ma;

  always_comb begin
    ma = mem_addr[7:0];
    mem_rdata = {m[ma + 8'd3], m[ma + 8'd2], m[ma + 8'd1], m[ma]};
  end

  always @(posedge clk) begin
    if (mem_write) begin
      m[ma] <= mem_wdata[7:0];
      if (mem_width != 2'b00) m[ma + 8'd1] <= mem_wdata[15:8];
      if (mem_width[1]) begin
        m[ma + 8'd2] <= mem_wdata[23:16];
        m[ma + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sword(input logic [7:0] a);
    return {sm[a + 8'd3], sm[a + 8'd2], sm[a + 8'd1], sm[a]};
  endfunction

  task automatic preload(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      m[a + 8'(i)]  = w[8*i +: 8];
      sm[a + 8'(i)] = w[8*i +: 8];
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];
  byte  gq[$];
  bit   rec = 1'b0;
  int   cyc = 0;
  int   wr_cnt = 0;

  // Scoreboard: check responses first, then record this cycle's grants.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] a;
    logic       bad_acc;
    if (rst_n) begin
      cyc++;
      if (mem_write) wr_cnt++;
      if (if_req_ready && d_req_ready) chk("gnt_both", 1, 0);

      if (if_rsp_valid) begin
        if (if_q.size() == 0) chk("if_spur", 1, 0);
        else begin
          e = if_q.pop_front();
          chk("if_data", if_rsp_data, e.data);
          chk("if_lat", 32'(cyc), 32'(e.cyc + 1));
        end
      end else if (if_q.size() > 0 && if_q[0].cyc < cyc) begin
        chk("if_miss", 0, 1);
        void'(if_q.pop_front());
      end

      if (d_rsp_valid) begin
        if (d_q.size() == 0) chk("d_spur", 1, 0);
        else begin
          e = d_q.pop_front();
          chk("d_data", d_rsp_data, e.data);
          chk("d_err", 32'(d_rsp_err), 32'(e.err));
          chk("d_lat", 32'(cyc), 32'(e.cyc + 1));
        end
      end else if (d_q.size() > 0 && d_q[0].cyc < cyc) begin
        chk("d_miss", 0, 1);
        void'(d_q.pop_front());
      end

      if (if_req_valid && if_req_ready) begin
        e.data = (CHK && if_addr[1:0] != 2'b00) ? 32'h0 : sword(if_addr[7:0]);
        e.err  = 1'b0;
        e.cyc  = cyc;
        if_q.push_back(e);
        if (rec) gq.push_back("I");
      end

      if (d_req_valid && d_req_ready) begin
        a = d_addr[7:0];
        bad_acc = CHK && ((d_width == 2'b11) || (d_width == 2'b01 && a[0]) ||
                          (d_width == 2'b10 && a[1:0] != 2'b00));
        e.data = bad_acc ? 32'h0 : sword(a);
        e.err  = bad_acc;
        e.cyc  = cyc;
        d_q.push_back(e);
        if (d_write && !bad_acc) begin
          sm[a] = d_wdata[7:0];
          if (d_width != 2'b00) sm[a + 8'd1] = d_wdata[15:8];
          if (d_width[1]) begin
            sm[a + 8'd2] = d_wdata[23:16];
            sm[a + 8'd3] = d_wdata[31:24];
          end
        end
        if (rec) gq.push_back("D");
      end
    end
  end

  task automatic fetch(input logic [31:0] a);
    logic ok;
    ok = 1'b0;
    if_addr = a;
    if_req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = if_req_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk("if_tmo", 0, 1);
    if_req_valid = 1'b0;
  endtask

  task automatic dreq(input logic wr, input logic [1:0] w, input logic [31:0] a,
                      input logic [31:0] wd);
    logic ok;
    ok = 1'b0;
    d_write = wr; d_width = w; d_addr = a; d_wdata = wd;
    d_req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = d_req_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk("d_tmo", 0, 1);
    d_req_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    string pat;
    pat = "DDDDIDDDDI";
    rst_n = 1'b0;
    if_req_valid = 0; if_addr = 0;
    d_req_valid = 0; d_addr = 0; d_write = 0; d_width = 2'b10; d_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      m[i]  = 8'(i * 7 + 3);
      sm[i] = 8'(i * 7 + 3);
    end
    preload(8'h10, 32'hDEADBEEF);
    preload(8'h40, 32'h55667788);

    // reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_if_v", 32'(if_rsp_valid), 0);
    chk("rst_d_v", 32'(d_rsp_valid), 0);
    chk("rst_err", 32'(d_rsp_err), 0);
    chk("rst_if_d", if_rsp_data, 0);
    chk("rst_d_d", d_rsp_data, 0);
    chk("rst_mw", 32'(mem_write), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // fetch only: single then 4 back-to-back
    fetch(32'h10);
    fetch(32'h10); fetch(32'h14); fetch(32'h18); fetch(32'h1C);
    drain();

    // contention: grant pattern D,D,D,D,IF repeating
    rec = 1'b1;
    fork
      begin fetch(32'h10); fetch(32'h14); end
      begin for (int i = 0; i < 8; i++) dreq(1'b0, 2'b10, 32'h40 + 32'(4 * i), 0); end
    join
    rec = 1'b0;
    drain();
    chk("gq_len", 32'(gq.size()), 10);
    for (int i = 0; i < 10 && i < gq.size(); i++) chk($sformatf("gnt%0d", i), 32'(gq[i]), 32'(pat[i]));

    // store word then load byte; one write cycle
    wr_cnt = 0;
    dreq(1'b1, 2'b10, 32'h20, 32'h11223344);
    dreq(1'b0, 2'b00, 32'h21, 0);
    drain();
    chk("st_wr_cnt", 32'(wr_cnt), 1);
    chk("ld_byte_sh", {24'h0, sm[8'h21]}, 32'h33);

    // store half then load word
    dreq(1'b1, 2'b01, 32'h40, 32'h0000ABCD);
    dreq(1'b0, 2'b10, 32'h40, 0);
    drain();
    chk("half_sh", sword(8'h40), 32'h5566ABCD);

    // unaligned store word and unaligned fetch
    wr_cnt = 0;
    dreq(1'b1, 2'b10, 32'h22, 32'hCAFEF00D);
    drain();
    chk("ua_wr_cnt", 32'(wr_cnt), CHK ? 0 : 1);
    dreq(1'b0, 2'b10, 32'h20, 0);
    dreq(1'b0, 2'b10, 32'h24, 0);
    fetch(32'h13);
    drain();

    // async reset mid-stream: contention until fetch wins, then reset with if rsp pending
    if_addr = 32'h10; d_addr = 32'h40; d_write = 1'b0; d_width = 2'b10;
    if_req_valid = 1'b1; d_req_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("starve_sat", 32'(dut.u_starve.cnt_q), 4);
    @(posedge clk); #1;
    chk("pre_rst_ifv", 32'(if_rsp_valid), 1);
    #1 rst_n = 1'b0;
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    #1;
    chk("arst_ifv", 32'(if_rsp_valid), 0);
    chk("arst_dv", 32'(d_rsp_valid), 0);
    chk("arst_cnt", 32'(dut.u_starve.cnt_q), 0);
    if_q.delete(); d_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    drain();
    fetch(32'h10);
    drain();
    chk("end_ifq", 32'(if_q.size()), 0);
    chk("end_dq", 32'(d_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
